// File: rtl/uart_program_loader.sv
// Assembles 3-byte UART groups (MSB first) into 24-bit words and writes them to the instruction RAM.
// Define UART_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte after the last word.
module uart_program_loader #(
  parameter logic [3:0] ACK_TIMEOUT = 4'd15,
  parameter logic [7:0] BASE_ADDR   = 8'h00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        ram_we,
  output logic [7:0]  ram_addr,
  output logic [23:0] ram_data,
  input  logic        ram_ack,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [8:0]  words_loaded
);

  typedef enum logic [3:0] {
    IDLE,
    GET_COUNT,
    GET_B2,
    GET_B1,
    GET_B0,
    WRITE,
    WAIT_ACK,
`ifdef UART_LOADER_CHECKSUM_EN
    CHECK,
`endif
    DONE,
    ERROR
  } state_t;

  state_t      state_q, state_d;
  logic [8:0]  count_q, count_d;
  logic [7:0]  addr_q, addr_d;
  logic [23:0] data_q, data_d;
  logic [8:0]  words_q, words_d;
  logic [3:0]  timer_q, timer_d;
`ifdef UART_LOADER_CHECKSUM_EN
  logic [7:0]  csum_q, csum_d;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
      addr_q  <= BASE_ADDR;
      data_q  <= '0;
      words_q <= '0;
      timer_q <= '0;
`ifdef UART_LOADER_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      words_q <= words_d;
      timer_q <= timer_d;
`ifdef UART_LOADER_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    addr_d  = addr_q;
    data_d  = data_q;
    words_d = words_q;
    timer_d = timer_q;
`ifdef UART_LOADER_CHECKSUM_EN
    csum_d  = csum_q;
`endif
    case (state_q)
      IDLE, DONE, ERROR: begin
        if (start) begin
          state_d = GET_COUNT;
          addr_d  = BASE_ADDR;
          words_d = '0;
          timer_d = '0;
`ifdef UART_LOADER_CHECKSUM_EN
          csum_d  = '0;
`endif
        end
      end
      GET_COUNT: begin
        if (rx_valid) begin
          count_d = (rx_data == 8'h00) ? 9'd256 : {1'b0, rx_data};
          state_d = GET_B2;
        end
      end
      GET_B2, GET_B1, GET_B0: begin
        if (rx_valid) begin
`ifdef UART_LOADER_CHECKSUM_EN
          csum_d = csum_q ^ rx_data;
`endif
          if (state_q == GET_B2) begin
            data_d[23:16] = rx_data;
            state_d       = GET_B1;
          end else if (state_q == GET_B1) begin
            data_d[15:8] = rx_data;
            state_d      = GET_B0;
          end else begin
            data_d[7:0] = rx_data;
            state_d     = WRITE;
          end
        end
      end
      WRITE: begin
        timer_d = '0;
        state_d = rx_valid ? ERROR : WAIT_ACK;
      end
      WAIT_ACK: begin
        if (rx_valid) begin
          state_d = ERROR;
        end else if (ram_ack) begin
          // The address advances on every ack, so a full 256-word load leaves it wrapped to 00.
          words_d = words_q + 9'd1;
          addr_d  = addr_q + 8'd1;
          if (words_d == count_q) begin
`ifdef UART_LOADER_CHECKSUM_EN
            state_d = CHECK;
`else
            state_d = DONE;
`endif
          end else begin
            state_d = GET_B2;
          end
        end else begin
          timer_d = timer_q + 4'd1;
          if (timer_d == ACK_TIMEOUT) state_d = ERROR;
        end
      end
`ifdef UART_LOADER_CHECKSUM_EN
      CHECK: begin
        if (rx_valid) state_d = (rx_data == csum_q) ? DONE : ERROR;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  assign ram_we       = (state_q == WRITE);
  assign ram_addr     = addr_q;
  assign ram_data     = data_q;
  assign busy         = !(state_q == IDLE || state_q == DONE || state_q == ERROR);
  assign done         = (state_q == DONE);
  assign error        = (state_q == ERROR);
  assign words_loaded = words_q;

endmodule

// File: tb/tb_uart_program_loader.sv
// Scoreboard bench for uart_program_loader: expected RAM writes are queued by the stimulus
// and popped by a monitor on every ram_we; status outputs are checked at directed points.
module tb_uart_program_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        ram_we;
  logic [7:0]  ram_addr;
  logic [23:0] ram_data;
  logic        ram_ack = 1'b0;
  logic        busy;
  logic        done;
  logic        error;
  logic [8:0]  words_loaded;

  logic        ack_en = 1'b1;
  logic [31:0] exp_q[$];
  logic [31:0] mon_exp;
  logic [7:0]  run_xor = 8'h00;
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  uart_program_loader dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .ram_we(ram_we),
    .ram_addr(ram_addr),
    .ram_data(ram_data),
    .ram_ack(ram_ack),
    .busy(busy),
    .done(done),
    .error(error),
    .words_loaded(words_loaded)
  );

  // RAM model: registered acknowledge one cycle after each write enable.
  always @(posedge clk) ram_ack <= ack_en && ram_we;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, actual, required);
    end
  endtask

  // Every write the DUT issues must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst && ram_we) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_write: got addr %0h data %0h, required no write", ram_addr, ram_data);
      end else begin
        mon_exp = exp_q.pop_front();
        checkOutput("write_addr", {24'h0, ram_addr}, {24'h0, mon_exp[31:24]});
        checkOutput("write_data", {8'h0, ram_data}, {8'h0, mon_exp[23:0]});
      end
    end
  end

  // One rx strobe; returns just after the edge that sampled it.
  task automatic applyStimulus(input logic [7:0] b);
    @(posedge clk); #1;
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic sendByte(input logic [7:0] b);
    applyStimulus(b);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic sendWord(input logic [7:0] addr, input logic [23:0] data);
    exp_q.push_back({addr, data});
    run_xor = run_xor ^ data[23:16] ^ data[15:8] ^ data[7:0];
    sendByte(data[23:16]);
    sendByte(data[15:8]);
    sendByte(data[7:0]);
  endtask

  task automatic beginLoad();
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    run_xor = 8'h00;
  endtask

  task automatic finishLoad();
`ifdef UART_LOADER_CHECKSUM_EN
    sendByte(run_xor);
`endif
  endtask

  task automatic waitFinish(input int budget);
    int n = 0;
    while (!(done || error) && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    if (!(done || error)) begin
      checks++;
      errors++;
      $display("[TB] FAIL finish_timeout: got no done/error in %0d cycles, required done or error", budget);
    end
  endtask

  task automatic doReset();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    ack_en = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("reset_we", {31'h0, ram_we}, 32'h0);
    checkOutput("reset_addr", {24'h0, ram_addr}, 32'h0);
    checkOutput("reset_data", {8'h0, ram_data}, 32'h0);
    checkOutput("reset_busy", {31'h0, busy}, 32'h0);
    checkOutput("reset_done", {31'h0, done}, 32'h0);
    checkOutput("reset_error", {31'h0, error}, 32'h0);
    checkOutput("reset_words", {23'h0, words_loaded}, 32'h0);

    $display("[TB] single word");
    beginLoad();
    checkOutput("single_busy", {31'h0, busy}, 32'h1);
    sendByte(8'h01);
    sendByte(8'hF0);
    sendByte(8'h00);
    exp_q.push_back({8'h00, 24'hF000AA});
    run_xor = 8'h5A;
    applyStimulus(8'hAA);
    checkOutput("single_we_next_cycle", {31'h0, ram_we}, 32'h1);
`ifndef UART_LOADER_CHECKSUM_EN
    @(posedge clk); #1;
    checkOutput("single_done_during_ack", {31'h0, done}, 32'h0);
    @(posedge clk); #1;
    checkOutput("single_done_latency", {31'h0, done}, 32'h1);
`else
    repeat (3) @(posedge clk);
    #1;
    sendByte(8'h5A);
`endif
    waitFinish(20);
    checkOutput("single_done", {31'h0, done}, 32'h1);
    checkOutput("single_words", {23'h0, words_loaded}, 32'h1);
    checkOutput("single_busy_low", {31'h0, busy}, 32'h0);
    checkOutput("single_error", {31'h0, error}, 32'h0);

    $display("[TB] three words with ignored start");
    beginLoad();
    checkOutput("three_done_cleared", {31'h0, done}, 32'h0);
    checkOutput("three_words_cleared", {23'h0, words_loaded}, 32'h0);
    sendByte(8'h03);
    sendWord(8'h00, 24'h112233);
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checkOutput("start_ignored_words", {23'h0, words_loaded}, 32'h1);
    checkOutput("start_ignored_busy", {31'h0, busy}, 32'h1);
    sendWord(8'h01, 24'h445566);
    sendWord(8'h02, 24'h778899);
    finishLoad();
    waitFinish(20);
    checkOutput("three_done", {31'h0, done}, 32'h1);
    checkOutput("three_words", {23'h0, words_loaded}, 32'h3);

    $display("[TB] full RAM");
    beginLoad();
    sendByte(8'h00);
    for (int i = 0; i < 256; i++) begin
      logic [7:0] b;
      b = 8'(i);
      sendWord(b, {b, ~b, b ^ 8'h5A});
    end
    finishLoad();
    waitFinish(20);
    checkOutput("full_done", {31'h0, done}, 32'h1);
    checkOutput("full_words", {23'h0, words_loaded}, 32'd256);
    checkOutput("full_addr_wrap", {24'h0, ram_addr}, 32'h0);

    $display("[TB] start with simultaneous byte");
    @(posedge clk); #1;
    start    = 1'b1;
    rx_valid = 1'b1;
    rx_data  = 8'h02;
    @(posedge clk); #1;
    start    = 1'b0;
    rx_valid = 1'b0;
    run_xor  = 8'h00;
    sendByte(8'h01);
    sendWord(8'h00, 24'h0A0B0C);
    finishLoad();
    waitFinish(20);
    checkOutput("sim_byte_done", {31'h0, done}, 32'h1);
    checkOutput("sim_byte_words", {23'h0, words_loaded}, 32'h1);

    $display("[TB] ack timeout");
    beginLoad();
    checkOutput("timeout_done_cleared", {31'h0, done}, 32'h0);
    ack_en = 1'b0;
    sendByte(8'h02);
    sendByte(8'h11);
    sendByte(8'h22);
    exp_q.push_back({8'h00, 24'h112233});
    applyStimulus(8'h33);
    @(posedge clk);
    repeat (14) @(posedge clk);
    #1;
    checkOutput("timeout_error_early", {31'h0, error}, 32'h0);
    checkOutput("timeout_busy_early", {31'h0, busy}, 32'h1);
    @(posedge clk); #1;
    checkOutput("timeout_error", {31'h0, error}, 32'h1);
    checkOutput("timeout_busy", {31'h0, busy}, 32'h0);
    ack_en = 1'b1;
    beginLoad();
    checkOutput("timeout_error_cleared", {31'h0, error}, 32'h0);
    checkOutput("timeout_restart_busy", {31'h0, busy}, 32'h1);
    doReset();

    $display("[TB] overrun");
    beginLoad();
    ack_en = 1'b0;
    sendByte(8'h02);
    sendByte(8'h44);
    sendByte(8'h55);
    exp_q.push_back({8'h00, 24'h445566});
    applyStimulus(8'h66);
    applyStimulus(8'h77);
    checkOutput("overrun_error", {31'h0, error}, 32'h1);
    checkOutput("overrun_busy", {31'h0, busy}, 32'h0);
    ack_en = 1'b1;
    sendByte(8'h12);
    checkOutput("overrun_rx_ignored", {31'h0, error}, 32'h1);

    $display("[TB] reset mid-load");
    beginLoad();
    sendByte(8'h03);
    sendWord(8'h00, 24'h010203);
    sendByte(8'hAB);
    checkOutput("midload_data", {8'h0, ram_data}, 32'hAB0203);
    checkOutput("midload_addr", {24'h0, ram_addr}, 32'h1);
    checkOutput("midload_words", {23'h0, words_loaded}, 32'h1);
    doReset();
    checkOutput("rst_we", {31'h0, ram_we}, 32'h0);
    checkOutput("rst_addr", {24'h0, ram_addr}, 32'h0);
    checkOutput("rst_data", {8'h0, ram_data}, 32'h0);
    checkOutput("rst_busy", {31'h0, busy}, 32'h0);
    checkOutput("rst_done", {31'h0, done}, 32'h0);
    checkOutput("rst_error", {31'h0, error}, 32'h0);
    checkOutput("rst_words", {23'h0, words_loaded}, 32'h0);
    sendByte(8'h05);
    checkOutput("rst_idle_busy", {31'h0, busy}, 32'h0);

`ifdef UART_LOADER_CHECKSUM_EN
    $display("[TB] checksum");
    beginLoad();
    sendByte(8'h01);
    sendWord(8'h00, 24'hF000AA);
    sendByte(8'h5A);
    waitFinish(20);
    checkOutput("csum_good_done", {31'h0, done}, 32'h1);
    beginLoad();
    sendByte(8'h01);
    sendWord(8'h00, 24'hF000AA);
    sendByte(8'h5B);
    waitFinish(20);
    checkOutput("csum_bad_error", {31'h0, error}, 32'h1);
    checkOutput("csum_bad_done", {31'h0, done}, 32'h0);
`endif

    repeat (2) @(posedge clk);
    #1;
    checkOutput("scoreboard_empty", exp_q.size(), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
